// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory and its byte-serial loader.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   function automatic int idx_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Fetch port and byte-serial load port of the instruction memory.
interface imem_loader_if #(
   parameter int LEN_WIDTH = 16
);
   logic                 fetch_req;
   logic [31:0]          fetch_addr;
   logic                 fetch_ready;
   logic                 fetch_valid;
   logic [31:0]          fetch_data;
   logic                 fetch_err;
   logic                 load_start;
   logic [LEN_WIDTH-1:0] load_len;
   logic                 load_byte_valid;
   logic [7:0]           load_byte;
   logic                 load_byte_ready;
   logic                 load_active;
   logic                 load_done;

   modport master (
      output fetch_req, fetch_addr, load_start, load_len, load_byte_valid, load_byte,
      input  fetch_ready, fetch_valid, fetch_data, fetch_err,
             load_byte_ready, load_active, load_done
   );

   modport slave (
      input  fetch_req, fetch_addr, load_start, load_len, load_byte_valid, load_byte,
      output fetch_ready, fetch_valid, fetch_data, fetch_err,
             load_byte_ready, load_active, load_done
   );
endinterface

// File: rtl/imem_byte_packer.sv
// Assembles a little-endian 32-bit word from four accepted bytes; strobes on the 4th byte.
module imem_byte_packer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_we,
   output logic [31:0] word
);
   logic [1:0]  byte_cnt;
   logic [23:0] buf_q;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         byte_cnt <= 2'd0;
         buf_q    <= 24'd0;
      end else if (byte_en) begin
         case (byte_cnt)
            2'd0:    buf_q[7:0]   <= byte_in;
            2'd1:    buf_q[15:8]  <= byte_in;
            2'd2:    buf_q[23:16] <= byte_in;
            default: ;
         endcase
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   // The last byte bypasses the buffer so the word is written on the same edge.
   assign word_we = byte_en && (byte_cnt == 2'd3);
   assign word    = {byte_in, buf_q};

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a registered valid/ready fetch port and a byte-serial program loader.
//
//  state   | meaning
//  IDLE    | fetches accepted, waiting for load_start
//  LOAD    | accepting bytes, writing words sequentially; fetches stalled
//  DONE    | one-cycle load_done pulse, then back to IDLE
module imem_loader
   import imem_pkg::*;
#(
   parameter int          DEPTH     = 256,
   parameter int          LEN_WIDTH = 16,
   parameter logic [31:0] FILL_WORD = NOP_WORD
) (
   input  logic          clk,
   input  logic          reset_n,
   imem_loader_if.slave  bus
);
   localparam int IW = idx_width(DEPTH);
   localparam int LW = IW + 1;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q;
   logic [LW-1:0] len_q;
   logic          clear;
   logic          byte_en;
   logic          word_we;
   logic [31:0]   word;
   logic          last_word;
   logic [31:0]   mem [DEPTH];

   logic          fetch_acc;
   logic          fetch_bad;
   logic [IW-1:0] fetch_idx;

   assign byte_en   = bus.load_byte_valid && (state_q == ST_LOAD);
   assign last_word = ({1'b0, ptr_q} == (len_q - LW'(1)));

   imem_byte_packer u_packer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .byte_en (byte_en),
      .byte_in (bus.load_byte),
      .word_we (word_we),
      .word    (word)
   );

   always_comb begin
      state_d             = state_q;
      clear               = 1'b0;
      bus.fetch_ready     = 1'b0;
      bus.load_byte_ready = 1'b0;
      bus.load_active     = 1'b0;
      bus.load_done       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.fetch_ready = 1'b1;
            if (bus.load_start) begin
               clear   = 1'b1;
               state_d = (bus.load_len == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            bus.load_byte_ready = 1'b1;
            bus.load_active     = 1'b1;
            if (word_we && last_word) state_d = ST_DONE;
         end
         ST_DONE: begin
            bus.load_done = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            ptr_q <= '0;
            // Lengths beyond the array are clamped so the loader stops at the last word.
            len_q <= (32'(bus.load_len) > 32'(DEPTH)) ? LW'(DEPTH) : LW'(bus.load_len);
         end else if (word_we) begin
            ptr_q <= ptr_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (word_we) mem[ptr_q] <= word;
   end

   // Any address bit above the index field flags an error instead of aliasing.
   assign fetch_acc = bus.fetch_req && (state_q == ST_IDLE);
   assign fetch_idx = bus.fetch_addr[2 +: IW];
   assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) ||
                      ((bus.fetch_addr >> (IW + 2)) != 32'd0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.fetch_valid <= 1'b0;
         bus.fetch_data  <= FILL_WORD;
         bus.fetch_err   <= 1'b0;
      end else begin
         bus.fetch_valid <= fetch_acc;
         if (fetch_acc) begin
            bus.fetch_err  <= fetch_bad;
            bus.fetch_data <= fetch_bad ? FILL_WORD : mem[fetch_idx];
         end
      end
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory for the RISC-V core with a registered fetch port and a byte-serial program loader. It replaces the fixed-content, combinational-read program memory: programs are streamed in byte by byte from the boot/UART path, assembled little-endian into 32-bit words and written sequentially. The core's fetch stage gets a one-cycle-latency valid/ready fetch port that stalls while a load is in progress. Misaligned and out-of-range fetches are reported as errors rather than silently aliasing.

## Interface
- DEPTH, 256, memory depth in 32-bit words; power of two, ≥ 4
- LEN_WIDTH, 16, width of the load length field
- FILL_WORD, 32'h0000_0013, word returned on error fetches and driven on fetch_data after reset (NOP, addi x0,x0,0)

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- fetch_req  in  1  fetch request
- fetch_addr  in  32  byte address of the instruction
- fetch_ready  out  1  fetch request accepted this cycle when high together with fetch_req
- fetch_valid  out  1  fetch_data/fetch_err valid (single-cycle pulse per accepted request)
- fetch_data  out  32  instruction word
- fetch_err  out  1  accepted fetch was misaligned or out of range
- load_start  in  1  start-of-load pulse
- load_len  in  LEN_WIDTH  number of words to load, sampled with load_start
- load_byte_valid  in  1  load byte present
- load_byte  in  8  load byte
- load_byte_ready  out  1  byte accepted when high together with load_byte_valid
- load_active  out  1  loader in LOAD state
- load_done  out  1  one-cycle pulse at end of load

## Operation
- FSM states: IDLE (reset state), LOAD, DONE.
- IDLE: fetch_ready=1, load_byte_ready=0. load_start → LOAD; word pointer and byte counter cleared; length latched as min(load_len, DEPTH). If the latched length is 0, go directly to DONE.
- LOAD: fetch_ready=0, load_byte_ready=1, load_active=1. Each accepted byte fills lane byte_cnt (0 = bits 7:0). The 4th byte is written as {byte, buf[23:0]} to word ptr in the same cycle; ptr increments; byte_cnt wraps to 0. The write of word len-1 → DONE. load_start is ignored in LOAD.
- DONE: single cycle, load_done=1, fetch_ready=0, load_byte_ready=0 → IDLE.
- Fetch: word index = fetch_addr[2 +: log2(DEPTH)]. Error if fetch_addr[1:0]≠0, or any fetch_addr bit above the index field is nonzero. An error fetch returns fetch_data=FILL_WORD and fetch_err=1. It never wraps onto a valid word.
- fetch_data and fetch_err hold their last values while fetch_valid=0.
- Memory contents are not reset and not initialised. Reset mid-load returns to IDLE; words already written persist, and the partial byte buffer is discarded.

## Timing
- Reset values: fetch_ready=1, fetch_valid=0, fetch_data=FILL_WORD, fetch_err=0, load_byte_ready=0, load_active=0, load_done=0.
- Fetch latency: request accepted in cycle N → fetch_valid=1 in cycle N+1. Back-to-back requests give a throughput of 1 per cycle.
- Load throughput: 1 byte per cycle. The memory write occurs at the edge that accepts the 4th byte. A fetch of that word can be issued at the earliest after DONE.
- Simultaneous fetch_req and load_start in IDLE: the fetch is accepted and its response is still delivered in the next cycle (during LOAD). Fetches then stall until IDLE.
- A load of L words, streamed with no gaps, ends with load_done exactly 4L cycles after the cycle following load_start.

## Structure
- Package imem_pkg holds:
  - the state enum (IDLE/LOAD/DONE)
  - the FILL_WORD default (NOP constant)
  - a helper function for the word-index width
- Sub-module imem_byte_packer: byte counter, 24-bit buffer, word-complete strobe and assembled word.
- The top level contains the FSM, the word pointer, the memory array and the fetch register.

## Test plan
- Reset, then fetch 0x0 → fetch_valid one cycle later, fetch_err=0; before reset release, fetch_data=0x00000013.
- Load with load_len=2 and bytes 83 01 30 00 83 02 60 00:
  - load_done pulses 8 cycles after LOAD entry.
  - Fetch 0x0 → 0x00300183.
  - Fetch 0x4 → 0x00600283.
- Fetch 0x2 → fetch_err=1, data 0x00000013. With DEPTH=256, fetch 0x400 → fetch_err=1, with no alias to word 0.
- load_len=0 → DONE the next cycle; memory unchanged. load_len=300 with DEPTH=256 → stops after 256 words.
- Throttle load_byte_valid at 50%: word values are correct. Assert reset_n low after 6 bytes, then reload: word 0 from the first load is intact, and the partial word is not written.
- Back-to-back fetches to 0x0, 0x4, 0x8 → three consecutive valid cycles with matching data. A load_start coincident with a fetch still returns that fetch.
